// File: rtl/npc_pc_unit.sv
// Fetch-stage PC register with next-PC select, return-address stack and redirect counter.
// Define NPC_ALIGN_CHK_EN to build the registered misaligned-fetch flag f_adel.
module npc_pc_unit #(
  parameter int PC_W                = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int RAS_DEPTH           = 4,
  parameter int DELAY_SLOT          = 0,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [PC_W-1:0]  d_pc,
  input  logic [15:0]      d_imm16,
  input  logic [25:0]      d_index,
  input  logic [PC_W-1:0]  d_rs,
  input  logic             d_beq,
  input  logic             d_bne,
  input  logic             d_cmp_eq,
  input  logic             d_j,
  input  logic             d_jal,
  input  logic             d_jr,
  input  logic             d_jr_ra,
  output logic [PC_W-1:0]  f_pc,
  output logic             f_flush,
  output logic [PC_W-1:0]  link_pc,
  output logic [PC_W-1:0]  ras_top,
  output logic             ras_hit,
  output logic             ras_ovf,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             f_adel
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PC_W-1:0] LINK_OFS = (DELAY_SLOT != 0) ? PC_W'(8) : PC_W'(4);
  localparam logic [PC_W-1:0] HI_MASK = ~PC_W'(28'hFFF_FFFF);
  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] d_pc4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] next_pc;
  logic            taken;
  logic            redirect;
  logic            do_push;
  logic            do_pop;

  assign seq_pc  = f_pc + PC_W'(4);
  assign d_pc4   = d_pc + PC_W'(4);
  assign br_tgt  = d_pc4 + {{(PC_W-18){d_imm16[15]}}, d_imm16, 2'b00};
  assign j_tgt   = (d_pc4 & HI_MASK) | PC_W'({d_index, 2'b00});
  assign taken   = (d_beq & d_cmp_eq) | (d_bne & ~d_cmp_eq);
  assign link_pc = d_pc + LINK_OFS;
  assign ras_top = (ras_cnt != '0) ? ras_mem[ras_ptr] : '0;
  assign f_flush = redirect & ~stall & FLUSH_EN;

  // Fixed priority jr > j/jal > branch; only the winner may touch the RAS.
  always_comb begin
    redirect = 1'b0;
    next_pc  = seq_pc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (d_jr) begin
      redirect = 1'b1;
      next_pc  = d_rs;
      do_pop   = d_jr_ra;
    end else if (d_j | d_jal) begin
      redirect = 1'b1;
      next_pc  = j_tgt;
      do_push  = d_jal;
    end else if (taken) begin
      redirect = 1'b1;
      next_pc  = br_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_pc         <= RESET_PC;
      redirect_cnt <= '0;
    end else if (!stall) begin
      f_pc <= next_pc;
      if (redirect) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

  // ras_ptr addresses the current top; a full push wraps over the oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_hit <= 1'b0;
      ras_ovf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      ras_hit <= 1'b0;
      if (!stall) begin
        if (do_push) begin
          ras_mem[ras_ptr + PTR_W'(1)] <= link_pc;
          ras_ptr <= ras_ptr + PTR_W'(1);
          if (ras_cnt == RAS_FULL) ras_ovf <= 1'b1;
          else                     ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
        end else if (do_pop && ras_cnt != '0) begin
          ras_hit <= (d_rs == ras_mem[ras_ptr]);
          ras_ptr <= ras_ptr - PTR_W'(1);
          ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
        end
      end
    end
  end

`ifdef NPC_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    f_adel <= 1'b0;
    else if (!stall) f_adel <= (next_pc[1:0] != 2'b00);
  end
`else
  assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Scoreboard bench for npc_pc_unit: stimulus pushes model expectations, a monitor pops and compares.
module tb_npc_pc_unit;

  localparam int DEPTH = 4;
  localparam int DS    = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_index;
  logic [31:0] d_rs;
  logic        d_beq, d_bne, d_cmp_eq, d_j, d_jal, d_jr, d_jr_ra;
  logic [31:0] f_pc;
  logic        f_flush;
  logic [31:0] link_pc;
  logic [31:0] ras_top;
  logic        ras_hit;
  logic        ras_ovf;
  logic [15:0] redirect_cnt;
  logic        f_adel;

  npc_pc_unit #(
    .PC_W(32), .RESET_PC(32'h0000_3000), .RAS_DEPTH(DEPTH), .DELAY_SLOT(DS), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .d_pc(d_pc), .d_imm16(d_imm16),
    .d_index(d_index), .d_rs(d_rs), .d_beq(d_beq), .d_bne(d_bne), .d_cmp_eq(d_cmp_eq),
    .d_j(d_j), .d_jal(d_jal), .d_jr(d_jr), .d_jr_ra(d_jr_ra), .f_pc(f_pc),
    .f_flush(f_flush), .link_pc(link_pc), .ras_top(ras_top), .ras_hit(ras_hit),
    .ras_ovf(ras_ovf), .redirect_cnt(redirect_cnt), .f_adel(f_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic [31:0] link;
    logic [31:0] top;
    logic        hit;
    logic        ovf;
    logic [15:0] cnt;
    logic        adel;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  logic        m_ovf;
  logic        m_hit;
  logic [15:0] m_cnt;
  logic        m_adel;
  int          checks = 0;
  int          failures = 0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_ras.delete();
    m_pc   = 32'h0000_3000;
    m_ovf  = 1'b0;
    m_hit  = 1'b0;
    m_cnt  = 16'd0;
    m_adel = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_f_pc"},   f_pc, 32'h0000_3000);
    check_output({tag, "_top"},    ras_top, 32'd0);
    check_output({tag, "_hit"},    {31'd0, ras_hit}, 32'd0);
    check_output({tag, "_ovf"},    {31'd0, ras_ovf}, 32'd0);
    check_output({tag, "_cnt"},    {16'd0, redirect_cnt}, 32'd0);
    check_output({tag, "_adel"},   {31'd0, f_adel}, 32'd0);
  endtask

  // Called just after a falling edge; drives one ID-stage cycle and queues what must follow.
  task automatic apply_stimulus(input bit st, input bit beq, input bit bne, input bit cmp,
                                input bit j, input bit jal, input bit jr, input bit jr_ra,
                                input logic [31:0] pc, input logic [31:0] rs,
                                input logic [15:0] imm, input logic [25:0] idx);
    exp_t        e;
    logic [31:0] nxt;
    logic [31:0] link;
    bit          redir;
    int          off;
    stall = st; d_beq = beq; d_bne = bne; d_cmp_eq = cmp; d_j = j; d_jal = jal;
    d_jr = jr; d_jr_ra = jr_ra; d_pc = pc; d_rs = rs; d_imm16 = imm; d_index = idx;

    link  = pc + ((DS != 0) ? 32'd8 : 32'd4);
    off   = int'($signed(imm));
    redir = 1'b1;
    if (jr)                            nxt = rs;
    else if (j || jal)                 nxt = ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
    else if ((beq && cmp) || (bne && !cmp)) nxt = pc + 32'd4 + 32'(off * 4);
    else begin
      redir = 1'b0;
      nxt   = m_pc + 32'd4;
    end

    e.flush = redir && !st && (DS == 0);
    e.link  = link;
    m_hit   = 1'b0;
    if (!st) begin
      if (jr && jr_ra) begin
        if (m_ras.size() > 0) begin
          m_hit = (rs == m_ras[$]);
          void'(m_ras.pop_back());
        end
      end else if (!jr && jal) begin
        m_ras.push_back(link);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (redir) m_cnt = m_cnt + 16'd1;
      m_pc = nxt;
`ifdef NPC_ALIGN_CHK_EN
      m_adel = (nxt % 4) != 0;
`else
      m_adel = 1'b0;
`endif
    end
    e.pc   = m_pc;
    e.top  = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
    e.hit  = m_hit;
    e.ovf  = m_ovf;
    e.cnt  = m_cnt;
    e.adel = m_adel;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    apply_stimulus(st, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 16'd0, 26'd0);
  endtask

  // Inputs stay stable from the falling edge, so combinational outputs are still valid here.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("f_pc",         f_pc, e.pc);
        check_output("f_flush",      {31'd0, f_flush}, {31'd0, e.flush});
        check_output("link_pc",      link_pc, e.link);
        check_output("ras_top",      ras_top, e.top);
        check_output("ras_hit",      {31'd0, ras_hit}, {31'd0, e.hit});
        check_output("ras_ovf",      {31'd0, ras_ovf}, {31'd0, e.ovf});
        check_output("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, e.cnt});
        check_output("f_adel",       {31'd0, f_adel}, {31'd0, e.adel});
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r_pc;
    logic [31:0] r_rs;
    logic [31:0] r_misc;
    int          sel;
    bit          b_beq, b_bne, b_j, b_jal, b_jr, b_ra;

    reset_n = 1'b0;
    stall = 0; d_pc = 0; d_imm16 = 0; d_index = 0; d_rs = 0;
    d_beq = 0; d_bne = 0; d_cmp_eq = 0; d_j = 0; d_jal = 0; d_jr = 0; d_jr_ra = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;

    repeat (3) idle(0);
    apply_stimulus(0, 1, 0, 1, 0, 0, 0, 0, 32'h3010, 32'd0, 16'hFFFC, 26'd0);
    apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0, 32'h3010, 32'd0, 16'hFFFC, 26'd0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h3020, 32'd0, 16'd0, 26'h000_0C40);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h3100, 32'h3024, 16'd0, 26'd0);
    idle(0);

    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'(i * 4), 32'd0, 16'd0, 26'h40);
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h14 - 32'(i * 4), 16'd0, 26'd0);

    apply_stimulus(1, 1, 0, 1, 0, 0, 1, 0, 32'h3200, 32'h4000, 16'h0010, 26'd0);
    apply_stimulus(0, 1, 0, 1, 0, 0, 1, 0, 32'h3200, 32'h4000, 16'h0010, 26'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h4000, 32'h3002, 16'd0, 26'd0);
    idle(0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      sel    = $urandom_range(0, 9);
      r_pc   = $urandom() & 32'hFFFF_FFFC;
      r_misc = $urandom();
      b_beq = (sel == 2) || (r_misc[0] && r_misc[1]);
      b_bne = (sel == 3) || (r_misc[2] && r_misc[3]);
      b_j   = (sel == 4) || (r_misc[4] && r_misc[5] && r_misc[6]);
      b_jal = (sel == 5) || (sel == 6);
      b_jr  = (sel >= 7);
      b_ra  = (sel == 7) || (sel == 8);
      if (b_ra && r_misc[7] && m_ras.size() > 0) r_rs = m_ras[$];
      else r_rs = $urandom() & ((r_misc[10:8] == 3'd0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      apply_stimulus(r_misc[13:11] == 3'd0, b_beq, b_bne, r_misc[14], b_j, b_jal, b_jr, b_ra,
                     r_pc, r_rs, r_misc[31:16], r_misc[25:0] ^ 26'h155_5555);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d pending exp=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
